// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants, field widths and helpers for the RAM responder slice.
package tl_ul_pkg;

  localparam int unsigned SizeW   = 4;
  localparam int unsigned SourceW = 2;
  localparam int unsigned SinkW   = 3;
  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 64;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGIC       = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] INTENT      = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;
  localparam logic [2:0] HINT_ACK = 3'd2;

  typedef enum logic {RespEmpty, RespFull} respStateE;

  // Low address bits that must be zero for a naturally aligned access of 2^size bytes.
  function automatic logic [2:0] alignMask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tl_ul_req_decode.sv
// Combinational A-request decoder: legality check and response classification per opcode.
module tl_ul_req_decode
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic [2:0]  opcode,
  input  logic [3:0]  size,
  input  logic [31:0] address,
  input  logic [7:0]  mask,
  input  logic        aCorrupt,
  output logic        legal,
  output logic        writeEn,
  output logic [7:0]  byteEn,
  output logic [2:0]  dOpcode,
  output logic        denied,
  output logic        dCorrupt
);

  localparam logic [AddrW:0] SpanBytes = (AddrW + 1)'(DEPTH_WORDS) << 3;

  logic [AddrW-1:0] offset;
  logic             inRange;
  logic             aligned;

  assign offset  = address - BASE_ADDR;
  // Widened compare so a window ending exactly at 2^32 still works.
  assign inRange = (address >= BASE_ADDR) && ({1'b0, offset} < SpanBytes);
  assign aligned = (address[2:0] & alignMask(size[1:0])) == 3'b000;
  assign legal   = inRange && (size <= 4'd3) && aligned;

  always_comb begin
    writeEn  = 1'b0;
    byteEn   = 8'h00;
    dOpcode  = ACK;
    denied   = 1'b1;
    dCorrupt = 1'b0;
    case (opcode)
      GET: begin
        dOpcode  = ACK_DATA;
        denied   = !legal;
        dCorrupt = !legal;
      end
      PUT_FULL, PUT_PARTIAL: begin
        writeEn = legal && !aCorrupt;
        byteEn  = writeEn ? mask : 8'h00;
        denied  = !(legal && !aCorrupt);
      end
      ARITH, LOGIC: begin
        dOpcode  = ACK_DATA;
        dCorrupt = 1'b1;
      end
      INTENT: begin
        dOpcode = HINT_ACK;
        denied  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tl_ul_ram_responder.sv
// Single-beat TL-UL slave backed by a synchronous RAM with a one-entry response register.
// Optional TL_RESP_STALL_EN adds LFSR-driven A-channel backpressure.
module tl_ul_ram_responder
  import tl_ul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_bits_opcode,
  input  logic [2:0]  a_bits_param,
  input  logic [3:0]  a_bits_size,
  input  logic [1:0]  a_bits_source,
  input  logic [31:0] a_bits_address,
  input  logic [7:0]  a_bits_mask,
  input  logic [63:0] a_bits_data,
  input  logic        a_bits_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_bits_opcode,
  output logic [1:0]  d_bits_param,
  output logic [3:0]  d_bits_size,
  output logic [1:0]  d_bits_source,
  output logic [2:0]  d_bits_sink,
  output logic        d_bits_denied,
  output logic [63:0] d_bits_data,
  output logic        d_bits_corrupt
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [DataW-1:0] mem [DEPTH_WORDS];

  logic            legal;
  logic            writeEn;
  logic [7:0]      byteEn;
  logic [2:0]      decOpcode;
  logic            decDenied;
  logic            decCorrupt;
  logic            stallOk;
  logic            aFire;
  logic            readEn;
  logic [31:0]     offset;
  logic [IdxW-1:0] wordIdx;
  respStateE       respState;
  respStateE       respStateNext;
  logic            unusedBits;

  tl_ul_req_decode #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_decode (
    .opcode   (a_bits_opcode),
    .size     (a_bits_size),
    .address  (a_bits_address),
    .mask     (a_bits_mask),
    .aCorrupt (a_bits_corrupt),
    .legal    (legal),
    .writeEn  (writeEn),
    .byteEn   (byteEn),
    .dOpcode  (decOpcode),
    .denied   (decDenied),
    .dCorrupt (decCorrupt)
  );

`ifdef TL_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 8'h5A;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stallOk = lfsr[0];
`else
  assign stallOk = 1'b1;
`endif

  assign a_ready = (!d_valid || d_ready) && stallOk;
  assign aFire   = a_valid && a_ready;
  assign readEn  = legal && (a_bits_opcode == GET);

  assign offset     = a_bits_address - BASE_ADDR;
  assign wordIdx    = offset[IdxW+2:3];
  assign unusedBits = ^{a_bits_param, offset[2:0], offset[31:IdxW+3]};

  // A write that fires in the same edge as reset is dropped.
  always_ff @(posedge clock) begin
    if (aFire && writeEn && !reset) begin
      for (int b = 0; b < 8; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][8*b +: 8] <= a_bits_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      respState <= RespEmpty;
    end else begin
      respState <= respStateNext;
    end
  end

  always_comb begin
    respStateNext = respState;
    case (respState)
      RespEmpty: begin
        if (aFire) respStateNext = RespFull;
      end
      RespFull: begin
        if (aFire) begin
          respStateNext = RespFull;
        end else if (d_ready) begin
          respStateNext = RespEmpty;
        end
      end
      default: respStateNext = RespEmpty;
    endcase
  end

  assign d_valid      = (respState == RespFull);
  assign d_bits_param = 2'd0;
  assign d_bits_sink  = 3'd0;

  // Loads only on fire, so the bundle holds while a response is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_bits_opcode  <= 3'd0;
      d_bits_size    <= 4'd0;
      d_bits_source  <= 2'd0;
      d_bits_denied  <= 1'b0;
      d_bits_corrupt <= 1'b0;
      d_bits_data    <= '0;
    end else if (aFire) begin
      d_bits_opcode  <= decOpcode;
      d_bits_size    <= a_bits_size;
      d_bits_source  <= a_bits_source;
      d_bits_denied  <= decDenied;
      d_bits_corrupt <= decCorrupt;
      d_bits_data    <= readEn ? mem[wordIdx] : '0;
    end
  end

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Scoreboard bench for tl_ul_ram_responder: directed test-plan cases plus random traffic.
module tb_tl_ul_ram_responder;

  localparam logic [31:0] Base  = 32'h8000_0000;
  localparam int          Depth = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_bits_opcode = '0;
  logic [2:0]  a_bits_param = '0;
  logic [3:0]  a_bits_size = '0;
  logic [1:0]  a_bits_source = '0;
  logic [31:0] a_bits_address = '0;
  logic [7:0]  a_bits_mask = '0;
  logic [63:0] a_bits_data = '0;
  logic        a_bits_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [1:0]  d_bits_source;
  logic [2:0]  d_bits_sink;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        d_bits_corrupt;

  tl_ul_ram_responder #(
    .BASE_ADDR   (Base),
    .DEPTH_WORDS (Depth)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_bits_opcode  (a_bits_opcode),
    .a_bits_param   (a_bits_param),
    .a_bits_size    (a_bits_size),
    .a_bits_source  (a_bits_source),
    .a_bits_address (a_bits_address),
    .a_bits_mask    (a_bits_mask),
    .a_bits_data    (a_bits_data),
    .a_bits_corrupt (a_bits_corrupt),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_bits_opcode  (d_bits_opcode),
    .d_bits_param   (d_bits_param),
    .d_bits_size    (d_bits_size),
    .d_bits_source  (d_bits_source),
    .d_bits_sink    (d_bits_sink),
    .d_bits_denied  (d_bits_denied),
    .d_bits_data    (d_bits_data),
    .d_bits_corrupt (d_bits_corrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  opc;
    logic [3:0]  size;
    logic [1:0]  src;
    logic        denied;
    logic        corrupt;
    logic [63:0] data;
  } expT;

  expT         expQ[$];
  logic [63:0] model [Depth];
  int          checks = 0;
  int          errors = 0;
  int          readyMode = 0;  // 0: always ready, 1: random, 2: never
  int          aReadyLow = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge clock);
      case (readyMode)
        0:       d_ready = 1'b1;
        1:       d_ready = 1'($urandom_range(0, 1));
        default: d_ready = 1'b0;
      endcase
    end
  end

  // Reference: derive the response and memory effect straight from the protocol rules.
  task automatic modelAccept(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                             input logic [31:0] addr, input logic [7:0] mask,
                             input logic [63:0] data, input logic corr);
    expT    e;
    longint a = longint'(addr);
    bit     legal;
    int     idx;
    legal = (a >= longint'(Base)) && (a < longint'(Base) + 8 * Depth) && (sz <= 3) &&
            ((a % (longint'(1) << sz)) == 0);
    idx = int'(((a - longint'(Base)) >>> 3) & (Depth - 1));
    e.size = sz;
    e.src  = src;
    e.data = 64'd0;
    e.corrupt = 1'b0;
    case (op)
      3'd4: begin
        e.opc = 3'd1; e.denied = !legal; e.corrupt = !legal;
        if (legal) e.data = model[idx];
      end
      3'd0, 3'd1: begin
        e.opc = 3'd0; e.denied = !(legal && !corr);
        if (legal && !corr) begin
          for (int b = 0; b < 8; b++) if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
      end
      3'd2, 3'd3: begin e.opc = 3'd1; e.denied = 1'b1; e.corrupt = 1'b1; end
      3'd5:       begin e.opc = 3'd2; e.denied = 1'b0; end
      default:    begin e.opc = 3'd0; e.denied = 1'b1; end
    endcase
    expQ.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                       input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic corr);
    int waitCycles = 0;
    @(negedge clock);
    a_valid = 1'b1; a_bits_opcode = op; a_bits_param = 3'($urandom); a_bits_size = sz;
    a_bits_source = src; a_bits_address = addr; a_bits_mask = mask; a_bits_data = data;
    a_bits_corrupt = corr;
    #1;
    while (!a_ready) begin
      waitCycles++;
      if (waitCycles > 200) begin
        checks++; errors++;
        $display("FAIL aAccept: a_ready=%0b after %0d cycles, required 1", a_ready, waitCycles);
        a_valid = 1'b0;
        return;
      end
      @(negedge clock);
      #1;
    end
    modelAccept(op, sz, src, addr, mask, data, corr);
    @(posedge clock);
    #1 a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", expQ.size());
    end
    @(negedge clock);
  endtask

  // Monitor: pops the scoreboard on every D fire, checks latency, stability and backpressure.
  initial begin
    expT         e;
    bit          prevFire = 0;
    bit          prevHold = 0;
    logic [84:0] heldBits = '0;
    logic [84:0] nowBits;
    forever begin
      @(negedge clock);
      #2;
      nowBits = {d_bits_opcode, d_bits_param, d_bits_size, d_bits_source, d_bits_sink,
                 d_bits_denied, d_bits_corrupt, d_bits_data};
      if (reset) begin
        prevFire = 0;
        prevHold = 0;
      end else begin
        if (!a_ready) aReadyLow++;
        if (prevFire) begin
          checks++;
          if (d_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: d_valid=%b one cycle after A fire, required 1", d_valid);
          end
        end
        if (prevHold) begin
          checks++;
          if (d_valid !== 1'b1 || nowBits !== heldBits) begin
            errors++;
            $display("FAIL dHold: d_valid=%b bits=%h, required 1 bits=%h",
                     d_valid, nowBits, heldBits);
          end
        end
        if (d_valid && !d_ready) begin
          checks++;
          if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL aReadyStall: a_ready=%b while D stalled, required 0", a_ready);
          end
        end
        if (d_valid === 1'b1 && d_ready) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("FAIL dUnexpected: D beat op=%0d src=%0d with nothing expected",
                     d_bits_opcode, d_bits_source);
          end else begin
            e = expQ.pop_front();
            if (d_bits_opcode !== e.opc || d_bits_size !== e.size || d_bits_source !== e.src ||
                d_bits_denied !== e.denied || d_bits_corrupt !== e.corrupt ||
                d_bits_param !== 2'd0 || d_bits_sink !== 3'd0 ||
                (e.opc == 3'd1 && d_bits_data !== e.data)) begin
              errors++;
              $display({"FAIL dBeat: got op=%0d size=%0d src=%0d den=%b cor=%b par=%0d ",
                        "sink=%0d data=%h; required op=%0d size=%0d src=%0d den=%b cor=%b ",
                        "par=0 sink=0 data=%h"},
                       d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied,
                       d_bits_corrupt, d_bits_param, d_bits_sink, d_bits_data, e.opc,
                       e.size, e.src, e.denied, e.corrupt, e.data);
            end
          end
        end
        prevFire = a_valid && a_ready;
        prevHold = d_valid && !d_ready;
        heldBits = nowBits;
      end
    end
  end

  initial begin
    logic [2:0]  others [5];
    logic [2:0]  op;
    logic [3:0]  sz;
    logic [31:0] ad;
    logic [63:0] old5;
    int          sel;
    others = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_bits_opcode !== 3'd0 || d_bits_size !== 4'd0 ||
        d_bits_source !== 2'd0 || d_bits_denied !== 1'b0 || d_bits_corrupt !== 1'b0 ||
        d_bits_data !== 64'd0 || d_bits_param !== 2'd0 || d_bits_sink !== 3'd0) begin
      errors++;
      $display("FAIL resetState: d_valid=%b op=%0d data=%h den=%b cor=%b, required all 0",
               d_valid, d_bits_opcode, d_bits_data, d_bits_denied, d_bits_corrupt);
    end
`ifndef TL_RESP_STALL_EN
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL resetReady: a_ready=%b after reset, required 1", a_ready);
    end
`endif

    // Give every RAM word a known value first.
    for (int i = 0; i < Depth; i++) begin
      issue(3'd0, 4'd3, 2'(i), Base + 32'(8 * i), 8'hFF, {$urandom, $urandom}, 1'b0);
    end
    drain();

    issue(3'd0, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0);
    issue(3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'h00, 64'd0, 1'b0);
    issue(3'd1, 4'd3, 2'd3, 32'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
    issue(3'd4, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
    issue(3'd4, 4'd3, 2'd1, 32'h7FFF_FFF8, 8'hFF, 64'd0, 1'b0);
    issue(3'd4, 4'd3, 2'd2, 32'h8000_2000, 8'hFF, 64'd0, 1'b0);
    issue(3'd4, 4'd2, 2'd3, 32'h8000_0002, 8'hFF, 64'd0, 1'b0);
    issue(3'd4, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
    for (int s = 0; s < 4; s++) issue(3'd4, 4'd3, 2'(s), Base + 32'(8 * s), 8'hFF, 64'd0, 1'b0);
    issue(3'd3, 4'd3, 2'd1, 32'h8000_0018, 8'hFF, 64'd5, 1'b0);
    issue(3'd5, 4'd3, 2'd2, 32'h8000_0018, 8'hFF, 64'd0, 1'b0);
    issue(3'd0, 4'd3, 2'd3, 32'h8000_0018, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    issue(3'd4, 4'd3, 2'd0, 32'h8000_0018, 8'hFF, 64'd0, 1'b0);
    drain();

    readyMode = 2;
    issue(3'd4, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
    repeat (3) begin
      @(negedge clock);
      #1;
      checks++;
      if (d_valid !== 1'b1 || a_ready !== 1'b0) begin
        errors++;
        $display("FAIL stallHold: d_valid=%b a_ready=%b, required 1 and 0", d_valid, a_ready);
      end
    end
    readyMode = 0;
    drain();

    readyMode = 1;
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3 || sel == 9) op = 3'd4;
      else if (sel <= 5) op = 3'd0;
      else if (sel <= 7) op = 3'd1;
      else op = others[$urandom_range(0, 4)];
      sz = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 6) == 0) ad = $urandom;
      else ad = Base + 32'($urandom_range(0, 8 * Depth - 1));
      if ($urandom_range(0, 9) != 0 && sz <= 4'd3) ad = ad & ~((32'd1 << sz) - 32'd1);
      issue(op, sz, 2'($urandom), ad, 8'($urandom), {$urandom, $urandom},
            1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end
    readyMode = 0;
    drain();

    // Reset during a held response: response discarded, colliding write dropped.
    old5 = model[5];
    readyMode = 2;
    issue(3'd4, 4'd3, 2'd2, Base + 32'h28, 8'hFF, 64'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    a_valid = 1'b1; a_bits_opcode = 3'd0; a_bits_size = 4'd3; a_bits_source = 2'd1;
    a_bits_address = Base + 32'h28; a_bits_mask = 8'hFF; a_bits_data = ~old5;
    a_bits_corrupt = 1'b0;
    @(posedge clock);
    #1 a_valid = 1'b0;
    expQ.delete();
    readyMode = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_bits_data !== 64'd0) begin
      errors++;
      $display("FAIL midReset: d_valid=%b data=%h, required 0 and 0", d_valid, d_bits_data);
    end
    issue(3'd4, 4'd3, 2'd3, Base + 32'h28, 8'hFF, 64'd0, 1'b0);
    drain();

`ifdef TL_RESP_STALL_EN
    checks++;
    if (aReadyLow == 0) begin
      errors++;
      $display("FAIL stallSeen: a_ready low in %0d cycles, required at least 1", aReadyLow);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
